// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants and types for the
// CORDIC sequencer and its datapath neighbours.
package cordic_pkg;

  localparam int ITERATIONS_DEF = 9;
  localparam int IDX_W_DEF = $clog2(ITERATIONS_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/cordic_sequencer.sv
// cordic_sequencer: FSM and iteration counter that
// steps the CORDIC datapath and registered angle ROM.
module cordic_sequencer
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = ITERATIONS_DEF,
  parameter int IDX_W      = $clog2(ITERATIONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_in,
  output logic             busy,
  output logic             done,
  output logic             mode,
  output logic             load_en,
  output logic             iter_en,
  output logic [IDX_W-1:0] shift_amt,
  output logic [IDX_W-1:0] angle_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITERATIONS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] cnt_n;
  logic             mode_q;
  logic             mode_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mode_q <= MODE_ROT;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_q <= mode_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_q;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_LOAD;
          mode_n  = mode_in;
        end
      end
      S_LOAD: begin
        state_n = S_ITER;
        cnt_n   = '0;
      end
      S_ITER: begin
        if (cnt == LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // abort beats a same-cycle start, so mode is not relatched
    if (abort) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      mode_n  = mode_q;
    end
  end

  assign mode = mode_q;

  // ROM is registered: look one index ahead, clamped at the end
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    load_en   = 1'b0;
    iter_en   = 1'b0;
    shift_amt = '0;
    angle_idx = '0;
    unique case (1'b1)
      (state == S_LOAD): begin
        busy    = 1'b1;
        load_en = 1'b1;
      end
      (state == S_ITER): begin
        busy      = 1'b1;
        iter_en   = 1'b1;
        shift_amt = cnt;
        angle_idx = (cnt == LAST) ? LAST : cnt + ONE;
      end
      (state == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb_cordic_sequencer: directed checks of the sequencer
// at 9 and 16 iterations, with a registered angle ROM model.
module tb_cordic_sequencer;
  import cordic_pkg::*;

  localparam int N  = 9;
  localparam int NB = 16;
  localparam int W  = $clog2(N);
  localparam int WB = $clog2(NB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mode_in = 1'b0;
  logic busy, done, mode, load_en, iter_en;
  logic [W-1:0] shift_amt, angle_idx;

  logic start_b = 1'b0;
  logic mode_in_b = 1'b0;
  logic busy_b, done_b, mode_b, load_en_b, iter_en_b;
  logic [WB-1:0] shift_amt_b, angle_idx_b;

  int n_run = 0;
  int n_fail = 0;

  logic [15:0] rom_tab [0:15];
  logic [15:0] rom_q;

  always #5 clk = ~clk;

  // atan(2^-i) in Q2.14, read with one cycle of latency
  always @(posedge clk) rom_q <= rom_tab[angle_idx];

  cordic_sequencer #(.ITERATIONS(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mode_in(mode_in), .busy(busy), .done(done), .mode(mode),
    .load_en(load_en), .iter_en(iter_en),
    .shift_amt(shift_amt), .angle_idx(angle_idx)
  );

  cordic_sequencer #(.ITERATIONS(NB)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(1'b0),
    .mode_in(mode_in_b), .busy(busy_b), .done(done_b),
    .mode(mode_b), .load_en(load_en_b), .iter_en(iter_en_b),
    .shift_amt(shift_amt_b), .angle_idx(angle_idx_b)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic m, output int n_it,
                        output int lat);
    n_it = 0;
    lat = -1;
    mode_in = m;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      step;
      chk("excl", 32'($countones({load_en, iter_en, done}) <= 1), 1);
      if (iter_en) n_it++;
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, n_it, lat, d0, d1;
    rom_tab[0] = 16'h3244; rom_tab[1] = 16'h1DAC;
    rom_tab[2] = 16'h0FAE; rom_tab[3] = 16'h07F5;
    rom_tab[4] = 16'h03FF; rom_tab[5] = 16'h0200;
    rom_tab[6] = 16'h0100; rom_tab[7] = 16'h0080;
    rom_tab[8] = 16'h0040; rom_tab[9] = 16'h0020;
    rom_tab[10] = 16'h0010; rom_tab[11] = 16'h0008;
    rom_tab[12] = 16'h0004; rom_tab[13] = 16'h0002;
    rom_tab[14] = 16'h0001; rom_tab[15] = 16'h0000;

    rst = 1'b1;
    start = 1'b1;
    step;
    step;
    chk("rst_ctl", {busy, done, load_en, iter_en}, 0);
    chk("rst_mode", mode, 0);
    chk("rst_shift", shift_amt, 0);
    chk("rst_angle", angle_idx, 0);
    chk("rst_b_ctl", {busy_b, done_b, load_en_b, iter_en_b}, 0);
    rst = 1'b0;
    start = 1'b0;
    step;

    // vectoring op: LOAD, 9 iterations, DONE
    mode_in = MODE_VEC;
    start = 1'b1;
    step;
    start = 1'b0;
    mode_in = MODE_ROT;
    chk("load_ctl", {busy, done, load_en, iter_en}, 4'b1010);
    chk("load_angle", angle_idx, 0);
    chk("load_mode", mode, 1);
    for (int i = 0; i < N; i++) begin
      step;
      chk("iter_ctl", {busy, done, load_en, iter_en}, 4'b1001);
      chk("iter_shift", shift_amt, i);
      chk("iter_angle", angle_idx, (i + 1 > N - 1) ? N - 1 : i + 1);
      chk("iter_mode", mode, 1);
      chk("iter_rom", rom_q, rom_tab[i]);
      if (i == 3) chk("rom_s3", rom_q, 16'b0000011111110101);
      if (i == 8) chk("rom_s8", rom_q, 16'b0000000001000000);
    end
    step;
    chk("done_ctl", {busy, done, load_en, iter_en}, 4'b0100);
    chk("done_shift", shift_amt, 0);
    chk("done_angle", angle_idx, 0);
    chk("done_mode", mode, 1);
    step;
    chk("idle_ctl", {busy, done, load_en, iter_en}, 0);
    chk("idle_mode", mode, 1);

    // abort at shift 4, then a clean full op
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i <= 4; i++) step;
    chk("pre_abort_shift", shift_amt, 4);
    abort = 1'b1;
    step;
    abort = 1'b0;
    chk("abort_ctl", {busy, done, load_en, iter_en}, 0);
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      step;
      if (done) nd++;
    end
    chk("abort_nodone", nd, 0);
    run_op(MODE_ROT, n_it, lat);
    chk("post_abort_iters", n_it, N);
    chk("post_abort_lat", lat, N + 1);
    chk("post_abort_mode", mode, 0);
    step;

    abort = 1'b1;
    start = 1'b1;
    step;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_beats_start", {busy, load_en}, 0);

    // start during ITER and DONE is ignored
    mode_in = MODE_VEC;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("ign_iter_shift", shift_amt, 3);
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step;
    end
    chk("ign_reach_done", done, 1);
    start = 1'b1;
    step;
    start = 1'b0;
    chk("ign_done_ctl", {busy, done, load_en, iter_en}, 0);
    step;
    chk("ign_done_idle", busy, 0);

    // start held high: back-to-back ops
    mode_in = MODE_ROT;
    start = 1'b1;
    d0 = -1;
    d1 = -1;
    for (int c = 1; c <= 40; c++) begin
      step;
      if (done) begin
        if (d0 < 0) d0 = c;
        else begin
          d1 = c;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_seen", 32'(d1 > 0), 1);
    chk("b2b_period", d1 - d0, 12);
    for (int c = 0; c < 20; c++) begin
      if (!busy && !done) break;
      step;
    end

    // reset at shift 6 together with start
    mode_in = MODE_VEC;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 7; i++) step;
    chk("pre_rst_shift", shift_amt, 6);
    rst = 1'b1;
    start = 1'b1;
    step;
    rst = 1'b0;
    start = 1'b0;
    chk("mid_rst_ctl", {busy, done, load_en, iter_en}, 0);
    chk("mid_rst_mode", mode, 0);
    chk("mid_rst_shift", shift_amt, 0);
    chk("mid_rst_angle", angle_idx, 0);
    nd = 0;
    for (int c = 0; c < 15; c++) begin
      step;
      if (done) nd++;
    end
    chk("mid_rst_nodone", nd, 0);

    // 16-iteration instance: clamp and latency
    mode_in_b = MODE_VEC;
    start_b = 1'b1;
    step;
    start_b = 1'b0;
    chk("b_load", load_en_b, 1);
    for (int i = 0; i < NB; i++) begin
      step;
      chk("b_iter", iter_en_b, 1);
      chk("b_shift", shift_amt_b, i);
      chk("b_angle", angle_idx_b, (i + 1 > NB - 1) ? NB - 1 : i + 1);
    end
    step;
    chk("b_done", {busy_b, done_b, iter_en_b}, 3'b010);
    chk("b_mode", mode_b, 1);
    step;
    chk("b_idle", {busy_b, done_b}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
